// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA feed a small FIFO that
// a four-state shifter drains onto the tx pin, with a STATUS register for polling.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int          CLK_DIV    = 16,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic        tx,
   output logic        tx_busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BCNT_MAX = BW'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            busy_q, busy_d;

   logic sel_data_s, sel_stat_s;
   logic fifo_empty_s, fifo_full_s;
   logic pop_s, push_req_s, push_ok_s, ovf_evt_s, stat_rd_s;
   logic wdata_unused;

   assign wdata_unused = ^mem_wdata[31:8];

   // Address decode and FIFO flags
   always_comb begin
      sel_data_s   = (mem_addr == BASE_ADDR);
      sel_stat_s   = (mem_addr == (BASE_ADDR + 32'd4));
      fifo_empty_s = (count_q == '0);
      fifo_full_s  = (count_q == DEPTH_C);
   end

   // Shifter FSM: next state, bit timing and registered tx value
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shreg_d = fifo_q[rd_ptr_q];
               state_d = S_START;
               bcnt_d  = BCNT_MAX;
               tx_d    = 1'b0;
            end else begin
               tx_d    = 1'b1;
            end
         end
         S_START: begin
            if (bcnt_q == '0) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
               bcnt_d  = BCNT_MAX;
               tx_d    = shreg_q[0];
            end else begin
               bcnt_d  = bcnt_q - BW'(1);
            end
         end
         S_DATA: begin
            if (bcnt_q == '0) begin
               bcnt_d = BCNT_MAX;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shreg_q[idx_q + 3'd1];
               end
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         S_STOP: begin
            // Chaining straight into START keeps back-to-back frames gap-free
            if (bcnt_q == '0) begin
               if (!fifo_empty_s) begin
                  pop_s   = 1'b1;
                  shreg_d = fifo_q[rd_ptr_q];
                  state_d = S_START;
                  bcnt_d  = BCNT_MAX;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               bcnt_d = bcnt_q - BW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   // FIFO push/pop bookkeeping, overflow flag and bus read data
   always_comb begin
      push_req_s = mem_we & sel_data_s;
      push_ok_s  = push_req_s & (~fifo_full_s | pop_s);
      ovf_evt_s  = push_req_s & ~push_ok_s;
      stat_rd_s  = mem_re & sel_stat_s;

      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A drop on the same edge as a STATUS read keeps the flag set
      if (ovf_evt_s) begin
         ovf_d = 1'b1;
      end else if (stat_rd_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      if (stat_rd_s) begin
         rdata_d = {28'd0, ovf_q, (state_q != S_IDLE), fifo_empty_s, fifo_full_s};
      end else begin
         rdata_d = 32'd0;
      end

      busy_d = (state_q != S_IDLE) | ~fifo_empty_s;
   end

   // Control and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         bcnt_q   <= '0;
         idx_q    <= 3'd0;
         shreg_q  <= 8'd0;
         tx_q     <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         rdata_q  <= 32'd0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         idx_q    <= idx_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
      end
   end

   // FIFO storage; contents are only meaningful under the pointers
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_q[wr_ptr_q] <= mem_wdata[7:0];
      end else begin
         fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
      end
   end

   assign tx        = tx_q;
   assign tx_busy   = busy_q;
   assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a transaction-level model predicts frames, STATUS
// reads and tx_busy; independent monitors decode the serial line and compare.
module tb_uart_tx_mmio;

   localparam int          DIV   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [31:0] mem_rdata;
   logic        tx;
   logic        tx_busy;

   uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .tx(tx), .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle", name, act, exp);
      end
   endtask

   // Reference model: the line is either idle or carrying one 10-bit frame that ends
   // at a known cycle; pending bytes wait in a queue of at most DEPTH entries.
   typedef struct {
      int         start;
      logic [7:0] data;
   } frame_t;

   int          cyc = 0;
   bit          m_busy = 1'b0;
   int          m_end = 0;
   logic [7:0]  m_q[$];
   bit          m_ovf = 1'b0;
   bit          rst_seen = 1'b1;
   frame_t      exp_frames[$];
   logic [31:0] exp_rd[$];
   bit          rd_due = 1'b0;
   bit          busy_exp = 1'b0;
   bit          busy_due = 1'b0;

   always @(posedge clk) begin : model
      bit pre_full, pre_empty, pre_act, pop, ovf_evt, stat_rd;
      frame_t fr;
      cyc++;
      if (!rst_n) begin
         m_busy = 1'b0;
         m_q.delete();
         m_ovf = 1'b0;
         exp_frames.delete();
         exp_rd.delete();
         rd_due = 1'b0;
         busy_exp = 1'b0;
         busy_due = 1'b1;
         rst_seen = 1'b1;
      end else begin
         rst_seen  = 1'b0;
         pre_full  = (m_q.size() == DEPTH);
         pre_empty = (m_q.size() == 0);
         pre_act   = m_busy;
         busy_exp  = pre_act || !pre_empty;
         busy_due  = 1'b1;
         pop = 1'b0;
         ovf_evt = 1'b0;
         stat_rd = mem_re && (mem_addr == BASE + 32'd4);
         if (!m_busy && !pre_empty) begin
            pop = 1'b1;
         end else if (m_busy && cyc == m_end) begin
            if (!pre_empty) pop = 1'b1;
            else m_busy = 1'b0;
         end
         if (pop) begin
            fr.start = cyc;
            fr.data  = m_q.pop_front();
            exp_frames.push_back(fr);
            m_busy = 1'b1;
            m_end  = cyc + 10 * DIV;
         end
         if (mem_we && mem_addr == BASE) begin
            if (!pre_full || pop) m_q.push_back(mem_wdata[7:0]);
            else ovf_evt = 1'b1;
         end
         if (mem_re) begin
            if (stat_rd) exp_rd.push_back({28'd0, m_ovf, pre_act, pre_empty, pre_full});
            else exp_rd.push_back(32'd0);
            rd_due = 1'b1;
         end else begin
            rd_due = 1'b0;
         end
         if (ovf_evt) m_ovf = 1'b1;
         else if (stat_rd) m_ovf = 1'b0;
      end
   end

   // Bus-side monitor: load data one cycle after mem_re, tx_busy every cycle
   always @(posedge clk) begin
      #1;
      if (rd_due) begin
         if (exp_rd.size() == 0) begin
            check("rdata_unexpected", 32'd1, 32'd0);
         end else begin
            check("rdata", mem_rdata, exp_rd.pop_front());
         end
      end
      if (busy_due) check("tx_busy", {31'd0, tx_busy}, {31'd0, busy_exp});
   end

   // Serial-line monitor: a UART receiver sampling mid-bit
   int         rx_cnt = -1;
   int         rx_start = 0;
   logic [7:0] rx_byte = 8'd0;

   always @(negedge clk) begin : rx_mon
      int j;
      frame_t f;
      if (rst_seen) begin
         rx_cnt = -1;
      end else begin
         if (rx_cnt < 0) begin
            if (tx == 1'b0) begin
               rx_cnt = 0;
               rx_start = cyc;
            end
         end else begin
            rx_cnt++;
         end
         if (rx_cnt >= 0) begin
            j = rx_cnt / DIV;
            if (rx_cnt % DIV == DIV / 2) begin
               if (j == 0) begin
                  check("start_bit", {31'd0, tx}, 32'd0);
               end else if (j <= 8) begin
                  rx_byte[j-1] = tx;
               end else begin
                  check("stop_bit", {31'd0, tx}, 32'd1);
                  if (exp_frames.size() == 0) begin
                     check("unexpected_frame", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                  end else begin
                     f = exp_frames.pop_front();
                     check("frame_start_cycle", rx_start, f.start);
                     check("frame_data", {24'd0, rx_byte}, {24'd0, f.data});
                  end
               end
            end
            if (rx_cnt == 10 * DIV - 1) rx_cnt = -1;
         end
      end
   end

   task automatic bus(input logic we, input logic re, input logic [31:0] addr, input logic [7:0] data);
      @(negedge clk);
      mem_we = we;
      mem_re = re;
      mem_addr = addr;
      mem_wdata = {24'($urandom), data};
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         mem_we = 1'b0;
         mem_re = 1'b0;
         mem_addr = 32'd0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((m_busy || m_q.size() != 0 || exp_frames.size() != 0) && t < 3000) begin
         idle(1);
         t++;
      end
      check("drain_timeout", {31'd0, (t >= 3000)}, 32'd0);
      idle(3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int sel;
      logic [31:0] a;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", {31'd0, tx}, 32'd1);
      check("reset_busy", {31'd0, tx_busy}, 32'd0);
      check("reset_rdata", mem_rdata, 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Single frame
      bus(1'b1, 1'b0, BASE, 8'h21);
      idle(45);
      drain();

      // Two contiguous frames
      bus(1'b1, 1'b0, BASE, 8'h55);
      bus(1'b1, 1'b0, BASE, 8'hAA);
      idle(1);
      drain();

      // Overflow: sixth byte dropped, STATUS clears the flag
      for (int i = 0; i < 6; i++) bus(1'b1, 1'b0, BASE, 8'(8'h10 + i));
      bus(1'b0, 1'b1, BASE + 32'd4, 8'd0);
      bus(1'b0, 1'b1, BASE + 32'd4, 8'd0);
      drain();

      // Store into a full FIFO on the stop-bit-end edge
      for (int i = 0; i < 5; i++) bus(1'b1, 1'b0, BASE, 8'(8'h30 + i));
      idle(1);
      t = 0;
      while (cyc != m_end - 1 && t < 200) begin
         idle(1);
         t++;
      end
      check("coincident_wait", {31'd0, (t >= 200)}, 32'd0);
      mem_we = 1'b1;
      mem_addr = BASE;
      mem_wdata = 32'h0000_00E7;
      bus(1'b0, 1'b1, BASE + 32'd4, 8'd0);
      idle(1);
      drain();

      // Reset in the middle of the data bits
      bus(1'b1, 1'b0, BASE, 8'hC3);
      idle(11);
      bus(1'b0, 1'b1, BASE + 32'd4, 8'd0);
      @(negedge clk);
      mem_re = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midframe_reset_tx", {31'd0, tx}, 32'd1);
      check("midframe_reset_busy", {31'd0, tx_busy}, 32'd0);
      check("midframe_reset_rdata", mem_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus(1'b0, 1'b1, BASE + 32'd4, 8'd0);
      @(posedge clk);
      #1;
      check("status_after_reset", mem_rdata, 32'h0000_0002);
      idle(50);

      // Foreign addresses, TXDATA load, simultaneous store+load
      bus(1'b1, 1'b0, BASE + 32'd8, 8'h77);
      bus(1'b0, 1'b1, 32'h2000_0000, 8'd0);
      @(posedge clk);
      #1;
      check("foreign_load", mem_rdata, 32'd0);
      bus(1'b0, 1'b1, BASE + 32'd4, 8'd0);
      bus(1'b1, 1'b1, BASE, 8'h5A);
      idle(1);
      drain();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 3);
         if (sel < 2) a = BASE;
         else if (sel == 2) a = BASE + 32'd4;
         else a = $urandom;
         bus(($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0), a, 8'($urandom));
      end
      idle(1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
